// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler: round-robin payload scheduler in front of the Ethernet frame packer.
// Two requesters share one fixed-length payload slot. Each payload starts with a tag byte
// {valid, src, seq[5:0]} sent MS dibit first, followed by the granted requester's body dibits.
// Unused dibits are padded with 00. If the granted requester underruns, the frame is cancelled.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   stall           from packer; low = packer consumes one payload dibit this cycle
//   axiiv, axiid    payload dibit valid / data to packer
//   cancelled       1-cycle pulse to packer aborting the current frame on underrun
//   req             req[n] = requester n holds a complete packet
//   d0/v0, d1/v1    requester head dibit and its valid
//   rd              rd[n] = pop head dibit of requester n this cycle
//   abort           abort[n] = 1-cycle pulse; requester n flushes its partial packet
//   grant           one-hot current/pending grant; 00 = idle slot
//   pkt_count       completed packets (wraps)
//   underrun_count  underrun events (saturates at 255)
module eth_tx_scheduler #(
  parameter int unsigned PAYLOAD_DIBITS = 1280,
  parameter int unsigned TAG_DIBITS     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic        axiiv,
  output logic [1:0]  axiid,
  output logic        cancelled,
  input  logic [1:0]  req,
  input  logic [1:0]  d0,
  input  logic [1:0]  d1,
  input  logic        v0,
  input  logic        v1,
  output logic [1:0]  rd,
  output logic [1:0]  abort,
  output logic [1:0]  grant,
  output logic [15:0] pkt_count,
  output logic [7:0]  underrun_count
);

  localparam int unsigned CntW = $clog2(PAYLOAD_DIBITS + 1);
  localparam logic [CntW-1:0] LastTag = CntW'(TAG_DIBITS - 1);
  localparam logic [CntW-1:0] LastDib = CntW'(PAYLOAD_DIBITS - 1);

  typedef enum logic [1:0] {StArb, StTag, StBody, StPad} state_e;

  state_e          state_q, state_d;
  logic            stall_q;
  logic [1:0]      grant_q, grant_d;
  logic            rr_q, rr_d;
  logic [7:0]      tag_q, tag_d;
  logic [CntW-1:0] dib_cnt_q, dib_cnt_d;
  logic [5:0]      seq0_q, seq0_d, seq1_q, seq1_d;
  logic [15:0]     pkt_count_q, pkt_count_d;
  logic [7:0]      underrun_count_q, underrun_count_d;

  logic [1:0] arb_grant;
  logic [7:0] arb_tag;
  logic       src;
  logic [1:0] d_src;
  logic       v_src;
  logic [1:0] tag_dibit;

  assign src   = grant_q[1];
  assign d_src = src ? d1 : d0;
  assign v_src = src ? v1 : v0;

  // rr_q holds the last served channel; on a tie the other channel wins.
  always_comb begin
    arb_grant = 2'b00;
    case (req)
      2'b11:   arb_grant = rr_q ? 2'b01 : 2'b10;
      2'b01:   arb_grant = 2'b01;
      2'b10:   arb_grant = 2'b10;
      default: arb_grant = 2'b00;
    endcase
    arb_tag = 8'h00;
    if (arb_grant != 2'b00) begin
      arb_tag = {1'b1, arb_grant[1], (arb_grant[1] ? seq1_q : seq0_q)};
    end
  end

  always_comb begin
    tag_dibit = tag_q[7:6];
    case (dib_cnt_q[1:0])
      2'd0:    tag_dibit = tag_q[7:6];
      2'd1:    tag_dibit = tag_q[5:4];
      2'd2:    tag_dibit = tag_q[3:2];
      default: tag_dibit = tag_q[1:0];
    endcase
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    rr_d             = rr_q;
    tag_d            = tag_q;
    dib_cnt_d        = dib_cnt_q;
    seq0_d           = seq0_q;
    seq1_d           = seq1_q;
    pkt_count_d      = pkt_count_q;
    underrun_count_d = underrun_count_q;
    axiid            = 2'b00;
    rd               = 2'b00;
    abort            = 2'b00;
    cancelled        = 1'b0;

    unique case (state_q)
      StArb: begin
        if (stall) begin
          grant_d = arb_grant;
          tag_d   = arb_tag;
        end else if (stall_q) begin
          // Slot start: grant is frozen, first tag dibit goes out this cycle.
          if (grant_q != 2'b00) rr_d = src;
          axiid     = tag_q[7:6];
          dib_cnt_d = CntW'(1);
          state_d   = StTag;
        end
        // stall low without a preceding high cycle: mid-slot after reset or underrun, send 00.
      end

      StTag: begin
        if (stall) begin
          abort   = grant_q;
          state_d = StArb;
        end else begin
          axiid     = tag_dibit;
          dib_cnt_d = dib_cnt_q + CntW'(1);
          if (dib_cnt_q == LastTag) begin
            state_d = (grant_q != 2'b00) ? StBody : StPad;
          end
        end
      end

      StBody: begin
        if (stall) begin
          // Slot ended before the payload completed: truncated packet.
          abort   = grant_q;
          state_d = StArb;
        end else begin
          rd = grant_q;
          if (!v_src) begin
            cancelled = 1'b1;
            abort     = grant_q;
            if (underrun_count_q != 8'hFF) underrun_count_d = underrun_count_q + 8'd1;
            state_d = StArb;
          end else begin
            axiid     = d_src;
            dib_cnt_d = dib_cnt_q + CntW'(1);
            if (dib_cnt_q == LastDib) begin
              pkt_count_d = pkt_count_q + 16'd1;
              if (src) seq1_d = seq1_q + 6'd1;
              else     seq0_d = seq0_q + 6'd1;
              state_d = StPad;
            end
          end
        end
      end

      StPad: begin
        if (stall) state_d = StArb;
      end

      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StArb;
      stall_q          <= 1'b0;
      grant_q          <= 2'b00;
      rr_q             <= 1'b1;
      tag_q            <= 8'h00;
      dib_cnt_q        <= '0;
      seq0_q           <= 6'd0;
      seq1_q           <= 6'd0;
      pkt_count_q      <= 16'd0;
      underrun_count_q <= 8'd0;
    end else begin
      state_q          <= state_d;
      stall_q          <= stall;
      grant_q          <= grant_d;
      rr_q             <= rr_d;
      tag_q            <= tag_d;
      dib_cnt_q        <= dib_cnt_d;
      seq0_q           <= seq0_d;
      seq1_q           <= seq1_d;
      pkt_count_q      <= pkt_count_d;
      underrun_count_q <= underrun_count_d;
    end
  end

  assign axiiv          = ~stall;
  assign grant          = grant_q;
  assign pkt_count      = pkt_count_q;
  assign underrun_count = underrun_count_q;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Testbench for eth_tx_scheduler: directed slots with random requester data, random slot
// shapes and underruns, checked against a slot-level reference model.
module tb_eth_tx_scheduler;

  localparam int PD = 1280;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        axiiv;
  logic [1:0]  axiid;
  logic        cancelled;
  logic [1:0]  req;
  logic [1:0]  d0, d1;
  logic        v0, v1;
  logic [1:0]  rd, abort, grant;
  logic [15:0] pkt_count;
  logic [7:0]  underrun_count;

  always #5 clk = ~clk;

  eth_tx_scheduler #(.PAYLOAD_DIBITS(PD), .TAG_DIBITS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .axiiv          (axiiv),
    .axiid          (axiid),
    .cancelled      (cancelled),
    .req            (req),
    .d0             (d0),
    .d1             (d1),
    .v0             (v0),
    .v1             (v1),
    .rd             (rd),
    .abort          (abort),
    .grant          (grant),
    .pkt_count      (pkt_count),
    .underrun_count (underrun_count)
  );

  int checks = 0;
  int errors = 0;
  int slot_n = 0;

  // Requester heads and pending pops.
  logic [1:0] head0, head1;
  logic [1:0] pop;

  // Reference model state.
  logic [5:0]  seq_m [2];
  logic        rr_m;
  logic [15:0] pkt_m;
  logic [7:0]  und_m;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    seq_m[0] = 6'd0;
    seq_m[1] = 6'd0;
    rr_m     = 1'b1;
    pkt_m    = 16'd0;
    und_m    = 8'd0;
  endtask

  // One clock: requesters pop on the edge, inputs change 1 ns later, outputs sampled 2 ns after.
  task automatic cycle(input logic st, input logic [1:0] vv);
    @(posedge clk);
    #1;
    if (pop[0]) head0 = 2'($urandom_range(0, 3));
    if (pop[1]) head1 = 2'($urandom_range(0, 3));
    stall = st;
    v0    = vv[0];
    v1    = vv[1];
    d0    = head0;
    d1    = head1;
    #1;
    pop = rd & ~abort;
  endtask

  // One arbitration gap plus a slot of len stall-low cycles. ur_at >= 0 drops the granted
  // requester's valid at that body dibit index.
  task automatic slot(input int len, input logic [1:0] rq, input int ur_at);
    int         g;
    logic       gv, alive, done, ec;
    logic [1:0] eg, vv, ea, er, eab;
    logic [7:0] tg, got_tag;
    logic [6:0] obs, ex, first_obs, first_exp;
    int         bad, first_i;

    req = rq;
    repeat (3) cycle(1'b1, 2'b11);
    gv = (rq != 2'b00);
    if (rq == 2'b11)      g = rr_m ? 0 : 1;
    else if (rq == 2'b10) g = 1;
    else                  g = 0;
    eg = !gv ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
    chk($sformatf("slot%0d_grant", slot_n), 32'(grant), 32'(eg));
    if (gv) rr_m = g[0];
    tg = gv ? {1'b1, g[0], seq_m[g]} : 8'h00;

    alive = 1'b1; done = 1'b0; bad = 0; first_i = -1; got_tag = 8'h00;
    first_obs = '0; first_exp = '0;
    for (int i = 0; i < len; i++) begin
      vv = 2'b11;
      if (gv && ur_at >= 0 && i == 4 + ur_at) vv[g] = 1'b0;
      cycle(1'b0, vv);
      ea = 2'b00; er = 2'b00; eab = 2'b00; ec = 1'b0;
      if (alive) begin
        if (i < 4) begin
          ea = 2'(tg >> (6 - 2 * i));
        end else if (gv && !done) begin
          er = eg;
          if (!vv[g]) begin
            ec    = 1'b1;
            eab   = eg;
            alive = 1'b0;
            if (und_m != 8'hFF) und_m++;
          end else begin
            ea = (g == 1) ? head1 : head0;
            if (i == PD - 1) begin
              done = 1'b1;
              pkt_m++;
              seq_m[g]++;
            end
          end
        end
      end
      if (i < 4) got_tag = {got_tag[5:0], axiid};
      obs = {axiiv, abort, cancelled, rd, axiid};
      ex  = {1'b1, eab, ec, er, ea};
      if (obs !== ex) begin
        if (bad == 0) begin
          first_i = i; first_obs = obs; first_exp = ex;
        end
        bad++;
      end
    end
    if (len >= 4) chk($sformatf("slot%0d_tag", slot_n), 32'(got_tag), 32'(tg));
    chk($sformatf("slot%0d_stream(first@%0d obs=%h exp=%h)", slot_n, first_i, first_obs,
                  first_exp), 32'(bad), 32'd0);

    cycle(1'b1, 2'b11);
    obs = {axiiv, abort, cancelled, rd, axiid};
    ex  = {1'b0, ((gv && alive && !done) ? eg : 2'b00), 1'b0, 2'b00, 2'b00};
    chk($sformatf("slot%0d_end", slot_n), 32'(obs), 32'(ex));
    chk($sformatf("slot%0d_pkt_count", slot_n), 32'(pkt_count), 32'(pkt_m));
    chk($sformatf("slot%0d_underrun_count", slot_n), 32'(underrun_count), 32'(und_m));
    slot_n++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int r, len, ua;
    logic [1:0] rq;

    rst = 1'b1; stall = 1'b1; req = 2'b00; v0 = 1'b1; v1 = 1'b1;
    head0 = 2'($urandom_range(0, 3));
    head1 = 2'($urandom_range(0, 3));
    d0 = head0; d1 = head1;
    pop = 2'b00;
    model_reset();

    repeat (3) cycle(1'b1, 2'b11);
    rst = 1'b0;
    cycle(1'b1, 2'b11);
    chk("reset_outputs", 32'({axiiv, abort, cancelled, rd, axiid, grant}), 32'd0);
    chk("reset_pkt_count", 32'(pkt_count), 32'd0);
    chk("reset_underrun_count", 32'(underrun_count), 32'd0);

    // Idle slot, then two ch0 packets (second tag carries seq 1).
    slot(PD, 2'b00, -1);
    slot(PD, 2'b01, -1);
    slot(PD, 2'b01, -1);

    // Both requesting: alternate.
    repeat (4) slot(PD, 2'b11, -1);

    // ch1 underrun at body dibit 100, then the same seq is re-tagged.
    slot(PD, 2'b10, 100);
    slot(PD, 2'b10, -1);

    // Slot ends at dibit 600 of a ch0 packet.
    slot(600, 2'b01, -1);

    // Random slot shapes.
    repeat (8) begin
      rq = 2'($urandom_range(0, 3));
      r  = int'($urandom_range(0, 3));
      ua = -1;
      case (r)
        0:       len = PD;
        1:       len = PD + 10;
        2:       len = int'($urandom_range(1, PD - 1));
        default: begin len = PD; ua = int'($urandom_range(0, PD - 5)); end
      endcase
      slot(len, rq, ua);
    end

    // Drive the underrun counter into saturation.
    repeat (260) slot(6, 2'b01, 0);
    chk("underrun_saturated", 32'(underrun_count), 32'd255);

    // Reset in the middle of a body.
    req = 2'b01;
    repeat (3) cycle(1'b1, 2'b11);
    repeat (50) cycle(1'b0, 2'b11);
    rst = 1'b1;
    cycle(1'b0, 2'b11);
    chk("midrst_outputs", 32'({abort, cancelled, rd, axiid, grant}), 32'd0);
    chk("midrst_pkt_count", 32'(pkt_count), 32'd0);
    chk("midrst_underrun_count", 32'(underrun_count), 32'd0);
    rst = 1'b0;
    model_reset();
    cycle(1'b1, 2'b11);
    slot(PD, 2'b11, -1);
    slot(PD, 2'b11, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
